// File: rtl/counter_pkg.sv
// counter_pkg: shared types and constants for the counter family.
//   COUNTER_WIDTH_DEFAULT : default counter width
//   dir_e                 : count direction (DIR_DOWN / DIR_UP)
//   cnt_op_e              : per-edge operation after priority decode
//   decode_op()           : clear > load > count > hold priority decode
package counter_pkg;

    localparam int unsigned COUNTER_WIDTH_DEFAULT = 8;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic [1:0] {
        OP_CLR   = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2,
        OP_HOLD  = 2'd3
    } cnt_op_e;

    function automatic cnt_op_e decode_op(input logic clr_n, input logic ld_n,
                                          input logic cnt_en);
        cnt_op_e op;
        if (!clr_n) begin
            op = OP_CLR;
        end else if (!ld_n) begin
            op = OP_LOAD;
        end else if (cnt_en) begin
            op = OP_COUNT;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next-count and terminal detect.
// Optional feature macro: COUNTER_UPDOWN_EN (adds the dir input and down logic).
//   q       in  WIDTH : current count
//   mod_max in  WIDTH : terminal value
//   dir     in  1     : direction (only with COUNTER_UPDOWN_EN)
//   q_next  out WIDTH : value to take on a count edge
//   at_tc   out 1     : count is at its terminal value
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] mod_max,
`ifdef COUNTER_UPDOWN_EN
    input  dir_e             dir,
`endif
    output logic [WIDTH-1:0] q_next,
    output logic             at_tc
);

    always_comb begin
        at_tc  = 1'b0;
        q_next = q;
`ifdef COUNTER_UPDOWN_EN
        if (dir == DIR_UP) begin
            // >= so a value loaded above the terminal wraps on the next count
            at_tc  = (q >= mod_max);
            q_next = at_tc ? '0 : q + 1'b1;
        end else begin
            at_tc  = (q == '0);
            q_next = at_tc ? mod_max : q - 1'b1;
        end
`else
        at_tc  = (q >= mod_max);
        q_next = at_tc ? '0 : q + 1'b1;
`endif
    end

endmodule

// File: rtl/mod_counter_n.sv
// mod_counter_n: WIDTH-bit '163-style counter with run-time modulus.
// Optional feature macro: COUNTER_UPDOWN_EN (adds the up port, down counting).
//   clk     in  1     : rising-edge clock
//   rst_n   in  1     : asynchronous reset, active-low
//   clr_n   in  1     : synchronous clear, active-low (also clears ovf)
//   ld_n    in  1     : synchronous parallel load, active-low
//   enp/ent in  1     : count enables; ent also gates rco
//   d       in  WIDTH : load data
//   mod_max in  WIDTH : terminal value (change only while not counting)
//   up      in  1     : 1 = up, 0 = down (only with COUNTER_UPDOWN_EN)
//   q       out WIDTH : count
//   rco     out 1     : combinational ripple carry, ent & at_tc
//   wrap    out 1     : registered pulse, high the cycle after a wrap edge
//   ovf     out 1     : sticky wrap flag
module mod_counter_n
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             ld_n,
    input  logic             enp,
    input  logic             ent,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] mod_max,
`ifdef COUNTER_UPDOWN_EN
    input  logic             up,
`endif
    output logic [WIDTH-1:0] q,
    output logic             rco,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q, q_d, q_next;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_tc;
    cnt_op_e          op;

    mod_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .q       (q_q),
        .mod_max (mod_max),
`ifdef COUNTER_UPDOWN_EN
        .dir     (dir_e'(up)),
`endif
        .q_next  (q_next),
        .at_tc   (at_tc)
    );

    always_comb begin
        op     = decode_op(clr_n, ld_n, enp & ent);
        q_d    = q_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        unique case (op)
            OP_CLR: begin
                q_d   = '0;
                ovf_d = 1'b0;
            end
            // A load never counts as a wrap, and leaves ovf alone.
            OP_LOAD: begin
                q_d = d;
            end
            OP_COUNT: begin
                q_d    = q_next;
                wrap_d = at_tc;
                ovf_d  = ovf_q | at_tc;
            end
            OP_HOLD: begin
                q_d = q_q;
            end
            default: begin
                q_d = q_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // rco ignores enp so a cascade can ripple-enable the next stage via ent.
    assign rco  = ent & at_tc;
    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// tb_mod_counter_n: directed, self-checking bench for mod_counter_n (WIDTH = 8).
// Expectations come from a small behavioural model and are queued per edge.
module tb_mod_counter_n;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n, clr_n, ld_n, enp, ent;
    logic [W-1:0] d, mod_max;
    logic [W-1:0] q;
    logic         rco, wrap, ovf;
`ifdef COUNTER_UPDOWN_EN
    logic         up;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] q;
        logic         rco;
        logic         wrap;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb[$];

    // Bench-side model state
    logic [W-1:0] m_q = '0;
    logic         m_w = 1'b0;
    logic         m_o = 1'b0;

    mod_counter_n #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_n   (clr_n),
        .ld_n    (ld_n),
        .enp     (enp),
        .ent     (ent),
        .d       (d),
        .mod_max (mod_max),
`ifdef COUNTER_UPDOWN_EN
        .up      (up),
`endif
        .q       (q),
        .rco     (rco),
        .wrap    (wrap),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_down();
`ifdef COUNTER_UPDOWN_EN
        return ~up;
`else
        return 1'b0;
`endif
    endfunction

    // Predict one edge, queue the expectation, clock, then compare.
    task automatic cycle(input string tag);
        exp_t e;
        logic tc, dn;
        dn  = model_down();
        tc  = dn ? (m_q == '0) : (m_q >= mod_max);
        m_w = 1'b0;
        if (!clr_n) begin
            m_q = '0;
            m_o = 1'b0;
        end else if (!ld_n) begin
            m_q = d;
        end else if (enp && ent) begin
            m_w = tc;
            m_o = m_o | tc;
            if (dn) m_q = tc ? mod_max : m_q - 8'd1;
            else    m_q = tc ? 8'd0 : m_q + 8'd1;
        end
        tc    = dn ? (m_q == '0) : (m_q >= mod_max);
        e.q    = m_q;
        e.rco  = ent & tc;
        e.wrap = m_w;
        e.ovf  = m_o;
        e.tag  = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".q"},    q,    e.q);
        chk({e.tag, ".rco"},  rco,  e.rco);
        chk({e.tag, ".wrap"}, wrap, e.wrap);
        chk({e.tag, ".ovf"},  ovf,  e.ovf);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_n   = 1'b1;
        ld_n    = 1'b1;
        enp     = 1'b0;
        ent     = 1'b0;
        d       = '0;
        mod_max = 8'd9;
`ifdef COUNTER_UPDOWN_EN
        up      = 1'b1;
`endif
        #2;
        chk("reset.q", q, 0);
        chk("reset.wrap", wrap, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.rco", rco, 0);
        ent = 1'b1;
        #1;
        chk("reset.rco_ent", rco, 0);
        rst_n = 1'b1;
        enp   = 1'b1;

        // Count to 5, then reset asynchronously between edges
        for (int i = 0; i < 5; i++) cycle("pre_rst");
        chk("pre_rst.q5", q, 5);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst.q", q, 0);
        chk("async_rst.wrap", wrap, 0);
        chk("async_rst.ovf", ovf, 0);
        m_q = '0;
        m_w = 1'b0;
        m_o = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_rst");
        chk("post_rst.q3", q, 3);

        // Decade divider from 0
        clr_n = 1'b0;
        cycle("clr");
        clr_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("dec.rco_pre", rco, (i == 9) ? 1 : 0);
            cycle("dec");
            chk("dec.q", q, (i + 1) % 10);
        end
        chk("dec.wrap_at0", wrap, 1);
        chk("dec.ovf_at0", ovf, 1);
        cycle("dec_after");
        chk("dec.wrap_gone", wrap, 0);
        chk("dec.ovf_sticky", ovf, 1);

        // Load beats count even at terminal; ovf survives the load
        ld_n = 1'b0;
        d    = 8'd9;
        cycle("ld9");
        d = 8'h42;
        cycle("prio_ld");
        chk("prio_ld.q", q, 8'h42);
        chk("prio_ld.wrap", wrap, 0);
        chk("prio_ld.ovf", ovf, 1);
        clr_n = 1'b0;
        cycle("prio_clr");
        chk("prio_clr.q", q, 0);
        chk("prio_clr.ovf", ovf, 0);
        clr_n = 1'b1;

        // Enables: hold at terminal with enp low
        enp     = 1'b0;
        mod_max = 8'd7;
        d       = 8'd7;
        cycle("ld7");
        ld_n = 1'b1;
        cycle("hold_enp");
        chk("hold_enp.q", q, 7);
        chk("hold_enp.rco", rco, 1);
        chk("hold_enp.wrap", wrap, 0);
        ent = 1'b0;
        #1;
        chk("ent0.rco", rco, 0);
        enp = 1'b1;
        cycle("hold_ent");
        chk("hold_ent.q", q, 7);

        // Load above terminal wraps to 0 on the next count
        ent     = 1'b1;
        enp     = 1'b0;
        mod_max = 8'd5;
        ld_n    = 1'b0;
        d       = 8'd200;
        cycle("ld200");
        ld_n = 1'b1;
        enp  = 1'b1;
        cycle("above_tc");
        chk("above_tc.q", q, 0);
        chk("above_tc.wrap", wrap, 1);

        // mod_max = 0 divides by one
        enp     = 1'b0;
        mod_max = 8'd0;
        cycle("mm0_idle");
        enp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("mm0");
            chk("mm0.q", q, 0);
            chk("mm0.wrap", wrap, 1);
            chk("mm0.rco", rco, 1);
        end

        // Full-range modulus behaves as a free-running binary counter
        enp     = 1'b0;
        mod_max = 8'hFF;
        ld_n    = 1'b0;
        d       = 8'hFE;
        cycle("ldFE");
        ld_n = 1'b1;
        enp  = 1'b1;
        cycle("free");
        chk("free.qFF", q, 8'hFF);
        cycle("free");
        chk("free.q00", q, 0);
        chk("free.wrap", wrap, 1);

`ifdef COUNTER_UPDOWN_EN
        // Down counting reloads mod_max from 0
        enp     = 1'b0;
        up      = 1'b0;
        mod_max = 8'd3;
        clr_n   = 1'b0;
        cycle("dn_clr");
        clr_n = 1'b1;
        enp   = 1'b1;
        chk("dn.rco_at0", rco, 1);
        cycle("dn");
        chk("dn.q3", q, 3);
        chk("dn.wrap3", wrap, 1);
        cycle("dn");
        chk("dn.q2", q, 2);
        cycle("dn");
        chk("dn.q1", q, 1);
        cycle("dn");
        chk("dn.q0", q, 0);
        chk("dn.rco0", rco, 1);
        cycle("dn");
        chk("dn.q3b", q, 3);
        cycle("dn");
        chk("dn.q2b", q, 2);
        up = 1'b1;
        cycle("flip_up");
        chk("flip_up.q", q, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
